// File: rtl/snn_neuron_sequencer.sv
// Sequencer for one delay-augmented LIF neuron: byte-wise parameter shadow with
// safe-point commit, plus a timestep runner driving enable and delay_clk.
module snn_neuron_sequencer #(
    parameter int M     = 2,
    parameter int Nbits = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           cfg_data,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic                 start,
    input  logic [7:0]           num_steps,
    input  logic [3:0]           step_len,
    output logic [M*Nbits-1:0]   weights,
    output logic [Nbits-1:0]     threshold,
    output logic [Nbits-1:0]     decay,
    output logic [Nbits-1:0]     refractory_period,
    output logic [3*M-1:0]       delay_values,
    output logic [M-1:0]         delays,
    output logic                 enable,
    output logic                 delay_clk,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_pending
);

    // state | meaning
    // IDLE  | waiting for start; config commits as soon as the shadow fills
    // RUN   | neuron enabled, one delay_clk per timestep; commits only on delay_clk
    // DONE  | one-cycle done pulse, then back to IDLE

    localparam int CFG_BITS = M*Nbits + 3*Nbits + 3*M + M;
    localparam int NBYTES   = (CFG_BITS + 7) / 8;
    localparam int BCW      = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int T_LSB    = M*Nbits;
    localparam int D_LSB    = T_LSB + Nbits;
    localparam int R_LSB    = D_LSB + Nbits;
    localparam int DV_LSB   = R_LSB + Nbits;
    localparam int DE_LSB   = DV_LSB + 3*M;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state;
    logic [BCW-1:0]      byte_cnt;
    logic [CFG_BITS-1:0] shadow;
    logic [7:0]          num_steps_q;
    logic [3:0]          step_len_q;
    logic [3:0]          step_cnt;
    logic [7:0]          steps_done;

    logic [BCW+2:0]      byte_shift;
    logic [CFG_BITS-1:0] byte_bits;
    logic [CFG_BITS-1:0] byte_mask;

    // Bits of the last byte that land above CFG_BITS are shifted out and lost.
    assign byte_shift = {byte_cnt, 3'b000};
    assign byte_bits  = CFG_BITS'(cfg_data) << byte_shift;
    assign byte_mask  = CFG_BITS'(8'hFF) << byte_shift;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            byte_cnt          <= '0;
            shadow            <= '0;
            cfg_pending       <= 1'b0;
            cfg_ready         <= 1'b1;
            weights           <= '0;
            threshold         <= '0;
            decay             <= '0;
            refractory_period <= '0;
            delay_values      <= '0;
            delays            <= '0;
            enable            <= 1'b0;
            delay_clk         <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            num_steps_q       <= '0;
            step_len_q        <= '0;
            step_cnt          <= '0;
            steps_done        <= '0;
        end else begin
            if (cfg_valid && cfg_ready) begin
                shadow <= (shadow & ~byte_mask) | byte_bits;
                if (byte_cnt == BCW'(NBYTES - 1)) begin
                    byte_cnt    <= '0;
                    cfg_pending <= 1'b1;
                    cfg_ready   <= 1'b0;
                end else begin
                    byte_cnt <= byte_cnt + BCW'(1);
                end
            end

            // cfg_ready is low whenever cfg_pending is high, so no byte lands here.
            if (cfg_pending && (state != RUN || delay_clk)) begin
                weights           <= shadow[0 +: M*Nbits];
                threshold         <= shadow[T_LSB +: Nbits];
                decay             <= shadow[D_LSB +: Nbits];
                refractory_period <= shadow[R_LSB +: Nbits];
                delay_values      <= shadow[DV_LSB +: 3*M];
                delays            <= shadow[DE_LSB +: M];
                cfg_pending       <= 1'b0;
                cfg_ready         <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        num_steps_q <= num_steps;
                        step_len_q  <= step_len;
                        step_cnt    <= '0;
                        steps_done  <= '0;
                        if (num_steps != 8'd0) begin
                            state     <= RUN;
                            enable    <= 1'b1;
                            busy      <= 1'b1;
                            delay_clk <= (step_len == 4'd0);
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (delay_clk) begin
                        if (steps_done == num_steps_q - 8'd1) begin
                            state     <= DONE;
                            enable    <= 1'b0;
                            busy      <= 1'b0;
                            delay_clk <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            steps_done <= steps_done + 8'd1;
                            step_cnt   <= '0;
                            delay_clk  <= (step_len_q == 4'd0);
                        end
                    end else begin
                        step_cnt  <= step_cnt + 4'd1;
                        delay_clk <= (step_cnt + 4'd1 == step_len_q);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snn_neuron_sequencer.sv
// Bench for snn_neuron_sequencer: timeline-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_snn_neuron_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  cfg_data = '0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic        start = 1'b0;
    logic [7:0]  num_steps = '0;
    logic [3:0]  step_len = '0;
    logic [7:0]  weights;
    logic [3:0]  threshold, decay, refractory_period;
    logic [5:0]  delay_values;
    logic [1:0]  delays;
    logic        enable, delay_clk, busy, done, cfg_pending;

    always #5 clk = ~clk;

    snn_neuron_sequencer #(.M(2), .Nbits(4)) dut (
        .clk(clk), .reset(reset),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .start(start), .num_steps(num_steps), .step_len(step_len),
        .weights(weights), .threshold(threshold), .decay(decay),
        .refractory_period(refractory_period), .delay_values(delay_values),
        .delays(delays), .enable(enable), .delay_clk(delay_clk), .busy(busy),
        .done(done), .cfg_pending(cfg_pending)
    );

    int n_pass = 0;
    int n_tot  = 0;
    int n      = 0;
    bit chk_on = 1'b0;

    // Reference model: a run is a window of cycles fixed at start; config is a byte
    // queue into a 32-bit word plus a pending flag.
    bit          have_run;
    int          run_t, run_num, run_len;
    logic [31:0] shadow_m;
    logic [27:0] comm_m;
    int          bc_m;
    bit          pend_m;

    bit          cur_valid, cur_start, cur_rst;
    logic [7:0]  cur_data, cur_num;
    logic [3:0]  cur_len;

    function automatic int run_end();
        return run_t + run_num * (run_len + 1);
    endfunction
    function automatic bit exp_en(int k);
        return have_run && k > run_t && k <= run_end();
    endfunction
    function automatic bit exp_dclk(int k);
        return exp_en(k) && ((k - run_t) % (run_len + 1) == 0);
    endfunction
    function automatic bit exp_done(int k);
        return have_run && k == run_end() + 1;
    endfunction
    function automatic bit is_idle(int k);
        return !have_run || k >= run_end() + 2;
    endfunction

    task automatic model_reset();
        have_run = 1'b0;
        shadow_m = '0;
        comm_m   = '0;
        bc_m     = 0;
        pend_m   = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, n, act, exp);
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("enable",       32'(enable),            32'(exp_en(n)));
            check("busy",         32'(busy),              32'(exp_en(n)));
            check("delay_clk",    32'(delay_clk),         32'(exp_dclk(n)));
            check("done",         32'(done),              32'(exp_done(n)));
            check("cfg_pending",  32'(cfg_pending),       32'(pend_m));
            check("cfg_ready",    32'(cfg_ready),         32'(!pend_m));
            check("weights",      32'(weights),           32'(comm_m[7:0]));
            check("threshold",    32'(threshold),         32'(comm_m[11:8]));
            check("decay",        32'(decay),             32'(comm_m[15:12]));
            check("refractory",   32'(refractory_period), 32'(comm_m[19:16]));
            check("delay_values", 32'(delay_values),      32'(comm_m[25:20]));
            check("delays",       32'(delays),            32'(comm_m[27:26]));
        end
    end

    // Drive one cycle of inputs, then advance the model across the following edge.
    task automatic cyc(input bit v, input logic [7:0] d, input bit s,
                       input logic [7:0] ns, input logic [3:0] sl, input bit r);
        bit commit, accept;
        cur_valid = v; cur_data = d; cur_start = s; cur_num = ns; cur_len = sl; cur_rst = r;
        cfg_valid = v; cfg_data = d; start = s; num_steps = ns; step_len = sl; reset = r;
        if (r) model_reset();
        @(posedge clk);
        #1;
        if (!cur_rst) begin
            commit = pend_m && (!exp_en(n) || exp_dclk(n));
            accept = cur_valid && !pend_m;
            if (accept) begin
                shadow_m[8*bc_m +: 8] = cur_data;
                if (bc_m == 3) begin
                    bc_m   = 0;
                    pend_m = 1'b1;
                end else begin
                    bc_m++;
                end
            end
            if (commit) begin
                comm_m = shadow_m[27:0];
                pend_m = 1'b0;
            end
            if (cur_start && is_idle(n)) begin
                have_run = 1'b1;
                run_t    = n;
                run_num  = int'(cur_num);
                run_len  = int'(cur_len);
            end
        end
        n++;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(1'b0, 8'h00, 1'b0, 8'd0, 4'd0, 1'b0);
    endtask

    logic [31:0] en_mask, dclk_mask, done_mask, busy_mask;
    int          cnt;
    logic [7:0]  bytes_a [4];

    initial begin
        model_reset();
        chk_on = 1'b1;

        // Reset and an idle 4-byte load
        cyc(1'b0, 8'h00, 1'b0, 8'd0, 4'd0, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 8'd0, 4'd0, 1'b1);
        check("lit_reset_ready",   32'(cfg_ready), 32'd1);
        check("lit_reset_weights", 32'(weights),   32'd0);
        bytes_a[0] = 8'h21; bytes_a[1] = 8'h43; bytes_a[2] = 8'h65; bytes_a[3] = 8'h07;
        for (int i = 0; i < 4; i++) cyc(1'b1, bytes_a[i], 1'b0, 8'd0, 4'd0, 1'b0);
        check("lit_ready_low", 32'(cfg_ready),   32'd0);
        check("lit_pending",   32'(cfg_pending), 32'd1);
        idle(1);
        check("lit_weights",    32'(weights),           32'h21);
        check("lit_threshold",  32'(threshold),         32'd3);
        check("lit_decay",      32'(decay),             32'd4);
        check("lit_refractory", 32'(refractory_period), 32'd5);
        check("lit_delay_vals", 32'(delay_values),      32'h36);
        check("lit_delays",     32'(delays),            32'd1);
        check("lit_ready_back", 32'(cfg_ready),         32'd1);

        // num_steps=3, step_len=2; a second start mid-run must be ignored
        idle(2);
        en_mask = '0; dclk_mask = '0; done_mask = '0; busy_mask = '0;
        cyc(1'b0, 8'h00, 1'b1, 8'd3, 4'd2, 1'b0);
        for (int k = 1; k <= 11; k++) begin
            en_mask[k] = enable; dclk_mask[k] = delay_clk; done_mask[k] = done; busy_mask[k] = busy;
            cyc(1'b0, 8'h00, (k == 4), (k == 4) ? 8'd7 : 8'd3, 4'd2, 1'b0);
        end
        check("lit_run_enable", en_mask,   32'h3FE);
        check("lit_run_busy",   busy_mask, 32'h3FE);
        check("lit_run_dclk",   dclk_mask, 32'h248);
        check("lit_run_done",   done_mask, 32'h400);

        // num_steps=0: immediate done, never enabled
        idle(3);
        en_mask = '0; dclk_mask = '0; done_mask = '0;
        cyc(1'b0, 8'h00, 1'b1, 8'd0, 4'd3, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            en_mask[k] = enable; dclk_mask[k] = delay_clk; done_mask[k] = done;
            idle(1);
        end
        check("lit_zero_done",   done_mask, 32'h2);
        check("lit_zero_enable", en_mask,   32'h0);
        check("lit_zero_dclk",   dclk_mask, 32'h0);

        // Reload during RUN, last byte coinciding with a delay_clk
        idle(2);
        bytes_a[0] = 8'hA5; bytes_a[1] = 8'h5A; bytes_a[2] = 8'hC3; bytes_a[3] = 8'h0F;
        cyc(1'b0, 8'h00, 1'b1, 8'd4, 4'd5, 1'b0);
        for (int k = 1; k <= 14; k++) begin
            if (k == 6)  check("lit_reload_dclk", 32'(delay_clk), 32'd1);
            if (k == 12) begin
                check("lit_reload_old",   32'(weights),   32'h21);
                check("lit_reload_ready", 32'(cfg_ready), 32'd0);
            end
            if (k == 13) begin
                check("lit_reload_new",   32'(weights),      32'hA5);
                check("lit_reload_thr",   32'(threshold),    32'hA);
                check("lit_reload_dv",    32'(delay_values), 32'h3C);
                check("lit_reload_rdy",   32'(cfg_ready),    32'd1);
            end
            cyc((k >= 3 && k <= 9), (k >= 3 && k <= 6) ? bytes_a[k-3] : 8'hEE,
                1'b0, 8'd0, 4'd0, 1'b0);
        end
        idle(15);

        // Reset mid-load and mid-run, then a fresh back-to-back load
        cyc(1'b0, 8'h00, 1'b1, 8'd5, 4'd3, 1'b0);
        cyc(1'b1, 8'h11, 1'b0, 8'd0, 4'd0, 1'b0);
        cyc(1'b1, 8'h22, 1'b0, 8'd0, 4'd0, 1'b0);
        idle(1);
        cyc(1'b0, 8'h00, 1'b0, 8'd0, 4'd0, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 8'd0, 4'd0, 1'b1);
        check("lit_rst_enable",  32'(enable),    32'd0);
        check("lit_rst_weights", 32'(weights),   32'd0);
        check("lit_rst_ready",   32'(cfg_ready), 32'd1);
        bytes_a[0] = 8'h21; bytes_a[1] = 8'h43; bytes_a[2] = 8'h65; bytes_a[3] = 8'h07;
        for (int i = 0; i < 4; i++) cyc(1'b1, bytes_a[i], 1'b0, 8'd0, 4'd0, 1'b0);
        idle(1);
        check("lit_fresh_weights", 32'(weights), 32'h21);
        check("lit_fresh_delays",  32'(delays),  32'd1);
        done_mask = '0;
        for (int k = 0; k < 30; k++) begin
            done_mask[0] = done_mask[0] | done;
            idle(1);
        end
        check("lit_rst_no_done", done_mask, 32'd0);

        // step_len=0 with continuous bytes
        cnt = 0;
        cyc(1'b1, 8'($urandom), 1'b1, 8'd6, 4'd0, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            if (delay_clk) cnt++;
            cyc(1'b1, 8'($urandom), 1'b0, 8'd0, 4'd0, 1'b0);
        end
        check("lit_len0_dclk_count", 32'(cnt), 32'd6);
        idle(4);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 25) == 0,
                8'($urandom_range(0, 6)), 4'($urandom_range(0, 4)),
                $urandom_range(0, 400) == 0);
        end
        idle(2);

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
